ingress_port_ctrl: RTL

Per-port ingress controller for the 4-port switch; the requester side of the crossbar arbiter. It buffers single-flit packets from a source and presents the head packet's request and one-hot destination mask to the arbiter. When granted, it pops the head and launches the flit to the crossbar one cycle later, aligned with the arbiter's registered mux select and active outputs. One instance exists per input port.

---
 rtl/packet_pkg.sv | 16 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/ingress_port_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/packet_pkg.sv
// Shared switch packet format: widths, the packed flit struct and its bit width.
package packet_pkg;

    localparam int NUM_PORTS  = 4;
    localparam int ADDR_WIDTH = 4;
    localparam int PAYLOAD_W  = 32;

    typedef struct packed {
        logic [1:0]            src;
        logic [ADDR_WIDTH-1:0] dst;
        logic [PAYLOAD_W-1:0]  data;
    } packet_t;

    localparam int PKT_W = $bits(packet_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a show-ahead head; pointers wrap naturally at DEPTH (power of two).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: head is only consumed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ingress_port_ctrl.sv
// Ingress side of one switch port: buffers packets, requests the arbiter for the head
// packet, drops undeliverable (dst==0) packets and launches granted flits to the crossbar.
module ingress_port_ctrl
    import packet_pkg::*;
#(
    parameter int PORT_ID    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // Input handshake: a packet transfers on a cycle where in_valid && in_ready;
    // in_valid/in_pkt must hold until that cycle, in_ready never depends on in_valid.
    input  logic                              in_valid,
    output logic                              in_ready,
    input  packet_t                           in_pkt,
    output logic                              port_req,
    output logic [ADDR_WIDTH-1:0]             port_dst,
    input  logic                              grant,
    output logic                              xbar_valid,
    output packet_t                           xbar_pkt,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic [15:0]                       sent_cnt,
    output logic [7:0]                        drop_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    packet_t     wr_pkt;
    packet_t     head_pkt;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        launch;
    logic        drop;
    logic [CW:0] count_next;

    always_comb begin
        wr_pkt     = in_pkt;
        wr_pkt.src = PORT_ID[1:0];
    end

    assign push     = in_valid && in_ready && !fifo_full;
    assign port_req = !fifo_empty && (head_pkt.dst != '0);
    assign port_dst = port_req ? head_pkt.dst : '0;
    assign launch   = port_req && grant;
    assign drop     = !fifo_empty && (head_pkt.dst == '0);
    assign pop      = launch || drop;

    assign count_next = {1'b0, fifo_level} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};

    sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wr_pkt),
        .head  (head_pkt),
        .count (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Registered launch lines up with the arbiter's registered mux select for the same grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready   <= 1'b0;
            xbar_valid <= 1'b0;
            xbar_pkt   <= '0;
            sent_cnt   <= '0;
            drop_cnt   <= '0;
        end else begin
            in_ready   <= (count_next < DEPTH_V);
            xbar_valid <= launch;
            if (launch) xbar_pkt <= head_pkt;
            if (xbar_valid) sent_cnt <= sent_cnt + 16'd1;
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule
